// File: rtl/pool_drain_if.sv
// Result stream from the pool-drain controller to the next-layer loader.
// Valid/ready handshake. A beat moves when valid and ready are both high.
interface pool_drain_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  valid;
    logic [DATA_WIDTH-1:0] data;
    logic                  last;
    logic                  ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/pool_drain_ctrl.sv
// Drains pooled/activated result bytes from the SA or FC result BRAM once a layer completes.
// The bytes go out in address order on a valid/ready stream. A pool-stage clear pulses at the end.
module pool_drain_ctrl #(
    parameter int CH_NUM        = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int SA_ADDR_WIDTH = 14,
    parameter int FC_ADDR_WIDTH = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     mode_i,
    input  logic [CH_NUM-1:0]        ch_mask_i,
    input  logic [SA_ADDR_WIDTH:0]   len_i,
    input  logic [CH_NUM-1:0]        pool_last_i,
    input  logic                     act_last_i,
    output logic                     sa_rden_o,
    output logic [SA_ADDR_WIDTH-1:0] sa_rdptr_o,
    input  logic [DATA_WIDTH-1:0]    sa_rdata_i,
    output logic                     fc_rden_o,
    output logic [FC_ADDR_WIDTH-1:0] fc_rdptr_o,
    input  logic [DATA_WIDTH-1:0]    fc_rdata_i,
    pool_drain_if.master             m,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     pool_clr_o
);

    typedef enum logic [1:0] {IDLE, WAIT, READ, DONE} state_t;

    state_t                  state, state_nxt;
    logic                    mode;
    logic [CH_NUM-1:0]       mask;
    logic [CH_NUM-1:0]       sticky;
    logic                    act_seen;
    logic [SA_ADDR_WIDTH:0]  len;
    logic [SA_ADDR_WIDTH:0]  issued;
    logic [SA_ADDR_WIDTH:0]  beats;
    logic                    inflight;
    logic                    out_vld, skid_vld;
    logic [DATA_WIDTH-1:0]   out_data, skid_data;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [2:0]              level;
    logic                    issue, pop, wait_done, start_ok;

    assign start_ok  = (state == IDLE) && start_i;
    assign wait_done = mode ? (act_seen | act_last_i)
                            : (((sticky | pool_last_i) & mask) == mask);

    // Entries held plus the read whose data lands this cycle. A new read is issued only
    // if it still fits once this cycle's pop has left, so the skid can never overflow.
    assign pop   = out_vld & m.ready;
    assign level = {2'b00, out_vld} + {2'b00, skid_vld} + {2'b00, inflight};
    assign issue = (state == READ) && (issued != len) && ((level - {2'b00, pop}) < 3'd2);

    assign sa_rden_o  = issue & ~mode;
    assign fc_rden_o  = issue & mode;
    assign sa_rdptr_o = sa_rden_o ? issued[SA_ADDR_WIDTH-1:0] : '0;
    assign fc_rdptr_o = fc_rden_o ? issued[FC_ADDR_WIDTH-1:0] : '0;
    assign rdata      = mode ? fc_rdata_i : sa_rdata_i;

    assign m.valid    = out_vld;
    assign m.data     = out_data;
    assign m.last     = out_vld && (beats == len - 1'b1);

    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE);
    assign pool_clr_o = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start_i) state_nxt = WAIT;
            WAIT: if (wait_done) state_nxt = (len != '0) ? READ : DONE;
            READ: if (pop && m.last) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Latched config, completion tracking and the address/beat counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode     <= 1'b0;
            mask     <= '0;
            len      <= '0;
            sticky   <= '0;
            act_seen <= 1'b0;
            issued   <= '0;
            beats    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (start_ok) begin
                mode     <= mode_i;
                mask     <= ch_mask_i;
                len      <= len_i;
                sticky   <= pool_last_i;
                act_seen <= act_last_i;
                issued   <= '0;
                beats    <= '0;
            end else begin
                if (state == WAIT) sticky <= sticky | pool_last_i;
                if (issue)         issued <= issued + 1'b1;
                if (pop)           beats  <= beats + 1'b1;
            end
        end
    end

    // Output register plus skid. The skid fills only while the head is stalled,
    // so the head data stays put until it is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld   <= 1'b0;
            out_data  <= '0;
            skid_vld  <= 1'b0;
            skid_data <= '0;
        end else if (!out_vld || pop) begin
            if (skid_vld) begin
                out_vld   <= 1'b1;
                out_data  <= skid_data;
                skid_vld  <= inflight;
                if (inflight) skid_data <= rdata;
            end else begin
                out_vld <= inflight;
                if (inflight) out_data <= rdata;
            end
        end else if (inflight) begin
            skid_vld  <= 1'b1;
            skid_data <= rdata;
        end
    end

endmodule

// File: tb/tb_pool_drain_ctrl.sv
// Directed self-checking bench for pool_drain_ctrl. Behavioural BRAMs return data one cycle after rden.
// Expected bytes: SA addr a -> a*7+3, FC addr a -> a^0xA5.
module tb_pool_drain_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, mode = 1'b0, act_last = 1'b0;
    logic [15:0] ch_mask = '0, pool_last = '0;
    logic [14:0] len = '0;
    logic        sa_rden, fc_rden;
    logic [13:0] sa_rdptr;
    logic [9:0]  fc_rdptr;
    logic [7:0]  sa_rdata = '0, fc_rdata = '0;
    logic        busy, done, pool_clr;
    logic [7:0]  sa_mem [0:63];
    logic [7:0]  fc_mem [0:15];
    int          pass_cnt = 0, total_cnt = 0;

    pool_drain_if #(.DATA_WIDTH(8)) m_if ();

    pool_drain_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start), .mode_i(mode), .ch_mask_i(ch_mask), .len_i(len),
        .pool_last_i(pool_last), .act_last_i(act_last),
        .sa_rden_o(sa_rden), .sa_rdptr_o(sa_rdptr), .sa_rdata_i(sa_rdata),
        .fc_rden_o(fc_rden), .fc_rdptr_o(fc_rdptr), .fc_rdata_i(fc_rdata),
        .m(m_if), .busy_o(busy), .done_o(done), .pool_clr_o(pool_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sa_rden) sa_rdata <= sa_mem[sa_rdptr[5:0]];
        if (fc_rden) fc_rdata <= fc_mem[fc_rdptr[3:0]];
    end

    // One cycle of control inputs, applied on the falling edge
    task automatic step(input logic st, input logic [15:0] pl, input logic al);
        @(negedge clk);
        start = st; pool_last = pl; act_last = al;
    endtask

    // Drain scenario: cycle 0 is the cycle after WAIT exit. stall=1 drives ready with the 1,0,0,1 pattern.
    task automatic run_drain(input bit md, input int n, input bit stall, input string tag);
        int issued = 0, popped = 0, last_i = -1, first_v = -1;
        bit prev_stall = 0, fin = 0, rd, other;
        logic [7:0] prev_data = '0, exp;
        int addr;
        for (int i = 0; i < 200 && !fin; i++) begin
            @(negedge clk);
            start = 0; pool_last = '0; act_last = 0;
            m_if.ready = stall ? ((i % 4 == 0) || (i % 4 == 3)) : 1'b1;
            #1;
            rd    = md ? fc_rden : sa_rden;
            addr  = md ? int'(fc_rdptr) : int'(sa_rdptr);
            other = md ? (sa_rden | (|sa_rdptr)) : (fc_rden | (|fc_rdptr));
            total_cnt++;
            if (other !== 1'b0) $display("FAIL %s other_pair cyc%0d: got 1 expected 0", tag, i);
            else pass_cnt++;
            if (rd) begin
                total_cnt++;
                if (addr !== (issued % (md ? 1024 : 16384)) || (issued == 0 && i != 0))
                    $display("FAIL %s rdptr cyc%0d: got %0d expected %0d (first read expected cyc0)", tag, i, addr, issued);
                else pass_cnt++;
                issued++;
            end
            total_cnt++;
            if (issued - popped - int'(m_if.valid & m_if.ready) > 2)
                $display("FAIL %s outstanding cyc%0d: got %0d expected <=2", tag, i,
                         issued - popped - int'(m_if.valid & m_if.ready));
            else pass_cnt++;
            if (m_if.valid) begin
                if (first_v < 0) begin
                    first_v = i;
                    total_cnt++;
                    if (i != 2) $display("FAIL %s first_valid: got cyc%0d expected cyc2", tag, i);
                    else pass_cnt++;
                end
                if (prev_stall) begin
                    total_cnt++;
                    if (m_if.data !== prev_data) $display("FAIL %s held_data cyc%0d: got %0h expected %0h", tag, i, m_if.data, prev_data);
                    else pass_cnt++;
                end
                if (m_if.ready) begin
                    exp = md ? (8'(popped) ^ 8'hA5) : 8'(popped * 7 + 3);
                    total_cnt++;
                    if (m_if.data !== exp || m_if.last !== (popped == n - 1))
                        $display("FAIL %s beat%0d: got data %0h last %0b expected data %0h last %0b",
                                 tag, popped, m_if.data, m_if.last, exp, popped == n - 1);
                    else pass_cnt++;
                    if (m_if.last) last_i = i;
                    popped++;
                end
            end
            prev_stall = m_if.valid & ~m_if.ready;
            prev_data  = m_if.data;
            if (done) begin
                fin = 1;
                total_cnt++;
                if (popped != n || issued != n || i != last_i + 1 || pool_clr !== 1'b1 || busy !== 1'b1)
                    $display("FAIL %s done: got beats %0d reads %0d cyc%0d clr %0b expected beats %0d reads %0d cyc%0d clr 1",
                             tag, popped, issued, i, pool_clr, n, n, last_i + 1);
                else pass_cnt++;
            end
        end
        if (!fin) begin
            total_cnt++;
            $display("FAIL %s timeout: got no done_o expected done_o within 200 cycles", tag);
        end
        @(negedge clk);
        m_if.ready = 1'b1;
        #1;
        total_cnt++;
        if ({busy, done, pool_clr, m_if.valid} !== 4'b0000)
            $display("FAIL %s after_done: got busy/done/clr/valid %b expected 0000", tag, {busy, done, pool_clr, m_if.valid});
        else pass_cnt++;
    endtask

    task automatic check_quiet(input string tag);
        total_cnt++;
        if ({busy, done, pool_clr, m_if.valid, m_if.last, sa_rden, fc_rden} !== 7'b0 ||
            sa_rdptr !== '0 || fc_rdptr !== '0 || m_if.data !== '0)
            $display("FAIL %s outputs: got busy%0b done%0b clr%0b valid%0b rden%0b%0b data %0h expected all 0",
                     tag, busy, done, pool_clr, m_if.valid, sa_rden, fc_rden, m_if.data);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        m_if.ready = 1'b1;
        repeat (2) @(negedge clk);
        #1 check_quiet("reset");
        @(negedge clk);
        rst = 1'b0;
        #1 check_quiet("reset_release");
    endtask

    task automatic test_sa_full(input bit stall, input string tag);
        mode = 0; ch_mask = 16'h000F; len = 15'd16;
        step(1, 16'h0001, 0);
        step(0, 16'h0000, 0);
        step(0, 16'h0002, 0);
        step(0, 16'h0000, 0);
        step(0, 16'h0004, 0);
        #1;
        total_cnt++;
        if (busy !== 1'b1 || sa_rden !== 1'b0) $display("FAIL %s waiting: got busy%0b rden%0b expected busy1 rden0", tag, busy, sa_rden);
        else pass_cnt++;
        step(0, 16'h0008, 0);
        run_drain(0, 16, stall, tag);
    endtask

    task automatic test_fc();
        mode = 1; ch_mask = 16'h0000; len = 15'd10;
        step(1, 16'h0000, 0);
        step(0, 16'hFFFF, 0);
        #1;
        total_cnt++;
        if (busy !== 1'b1 || fc_rden !== 1'b0) $display("FAIL fc_wait: got busy%0b rden%0b expected busy1 rden0", busy, fc_rden);
        else pass_cnt++;
        step(0, 16'h0000, 1);
        run_drain(1, 10, 0, "fc");
    endtask

    task automatic test_len0();
        mode = 0; ch_mask = 16'h0001; len = 15'd0;
        step(1, 16'h0000, 0);
        step(0, 16'h0001, 0);
        run_drain(0, 0, 0, "len0");
    endtask

    task automatic test_early_pulse_restart();
        mode = 0; ch_mask = 16'h0008; len = 15'd4;
        step(0, 16'h0008, 0);
        step(1, 16'h0000, 0);
        for (int k = 0; k < 4; k++) begin
            step(0, 16'h0000, 0);
            #1;
            total_cnt++;
            if (busy !== 1'b1 || sa_rden !== 1'b0) $display("FAIL early_pulse wait%0d: got busy%0b rden%0b expected busy1 rden0", k, busy, sa_rden);
            else pass_cnt++;
        end
        mode = 1; ch_mask = 16'h0000; len = 15'd0;
        step(1, 16'h0000, 0);
        step(0, 16'h0000, 1);
        step(0, 16'h0000, 0);
        #1;
        total_cnt++;
        if (busy !== 1'b1 || sa_rden !== 1'b0 || fc_rden !== 1'b0 || done !== 1'b0)
            $display("FAIL restart_ignored: got busy%0b rden%0b%0b done%0b expected busy1 rden00 done0", busy, sa_rden, fc_rden, done);
        else pass_cnt++;
        step(0, 16'h0008, 0);
        run_drain(0, 4, 0, "early_pulse");
    endtask

    task automatic test_reset_mid();
        int popped = 0;
        bit hit = 0;
        mode = 0; ch_mask = 16'h0001; len = 15'd16;
        step(1, 16'h0001, 0);
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            start = 0; pool_last = '0; m_if.ready = 1'b1;
            #1;
            if (m_if.valid && popped == 5) hit = 1;
            else if (m_if.valid) popped++;
        end
        total_cnt++;
        if (!hit) $display("FAIL rst_mid reach_beat5: got %0d beats expected beat 5 shown", popped);
        else pass_cnt++;
        rst = 1'b1;
        #1 check_quiet("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            total_cnt++;
            if ({done, pool_clr, busy, m_if.valid} !== 4'b0000)
                $display("FAIL rst_mid quiet%0d: got done/clr/busy/valid %b expected 0000", k, {done, pool_clr, busy, m_if.valid});
            else pass_cnt++;
        end
        step(1, 16'h0001, 0);
        step(0, 16'h0000, 0);
        run_drain(0, 16, 0, "rst_mid_redrain");
    endtask

    initial begin
        for (int a = 0; a < 64; a++) sa_mem[a] = 8'(a * 7 + 3);
        for (int a = 0; a < 16; a++) fc_mem[a] = 8'(a) ^ 8'hA5;
        m_if.ready = 1'b1;
        test_reset();
        test_sa_full(0, "sa_full");
        test_sa_full(1, "sa_stall");
        test_fc();
        test_len0();
        test_early_pulse_restart();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
